seq_alu: RTL and testbench

- Parametrised, registered successor to the 4-bit combinational ALU.
- Operand width is set by WIDTH.
- Has valid/ready handshakes on input and output.
- Adds ADD, SUB and an iterative shift-add MUL to the existing shift and logic ops.
- Sits between the register-file read stage and writeback. Only one operation is in flight at a time; single-cycle ops can issue back-to-back.

---
 rtl/seq_alu_if.sv | 30 +++
 rtl/seq_alu.sv | 207 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Handshake and result bundle between the register-file read stage, seq_alu and writeback.
// The master side presents operations and accepts results; seq_alu sits on the slave side.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic             overflow;
  logic             negative;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, opcode, a, b, cin, out_ready,
    input  in_ready, out_valid, y, cout, overflow, negative, zero, illegal
  );

  modport slave (
    input  in_valid, opcode, a, b, cin, out_ready,
    output in_ready, out_valid, y, cout, overflow, negative, zero, illegal
  );
endinterface

// File: rtl/seq_alu.sv
// Registered WIDTH-bit ALU with valid/ready handshakes and an iterative shift-add multiplier.
// Define SEQ_ALU_STICKY_OVF_EN to add the ovf_clr input and the sticky_ovf output.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
`ifdef SEQ_ALU_STICKY_OVF_EN
  input  logic     ovf_clr,
  output logic     sticky_ovf,
`endif
  seq_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH) + 1;
  localparam int MSB = WIDTH - 1;

  typedef enum logic [3:0] {
    OP_LSL = 4'b0000,
    OP_LSR = 4'b0001,
    OP_ASR = 4'b0010,
    OP_NOT = 4'b0011,
    OP_AND = 4'b0100,
    OP_OR  = 4'b0101,
    OP_XOR = 4'b0110,
    OP_ADD = 4'b0111,
    OP_SUB = 4'b1000,
    OP_MUL = 4'b1001
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   y_q;
  logic               cout_q;
  logic               ovf_q;
  logic               neg_q;
  logic               zero_q;
  logic               ill_q;
  logic               out_valid_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [SHW-1:0]     cnt_q;

  logic               accept;
  logic               start_mul;
  logic               mul_last;
  logic               load;
  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     lsl_w;
  logic [WIDTH:0]     lsr_w;
  logic signed [WIDTH:0] asr_w;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   op_y;
  logic               op_cout;
  logic               op_ovf;
  logic               op_ill;
  logic [WIDTH-1:0]   y_d;
  logic               cout_d;
  logic               ovf_d;
  logic               ill_d;

  assign bus.in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign start_mul    = accept && (bus.opcode == OP_MUL);
  assign mul_last     = (state_q == BUSY) && (cnt_q == SHW'(WIDTH - 1));

  // Shifts carry one guard bit so the last bit shifted out lands in the extra position.
  assign sh       = bus.b[SHW-1:0];
  assign lsl_w    = {1'b0, bus.a} << sh;
  assign lsr_w    = {bus.a, 1'b0} >> sh;
  assign asr_w    = $signed({bus.a, 1'b0}) >>> sh;
  assign add_w    = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
  assign sub_w    = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    op_y    = '0;
    op_cout = 1'b0;
    op_ovf  = 1'b0;
    op_ill  = 1'b0;
    case (bus.opcode)
      OP_LSL: {op_cout, op_y} = lsl_w;
      OP_LSR: {op_y, op_cout} = lsr_w;
      OP_ASR: {op_y, op_cout} = asr_w;
      OP_NOT: op_y = ~bus.a;
      OP_AND: op_y = bus.a & bus.b;
      OP_OR:  op_y = bus.a | bus.b;
      OP_XOR: op_y = bus.a ^ bus.b;
      OP_ADD: begin
        {op_cout, op_y} = add_w;
        op_ovf = (bus.a[MSB] == bus.b[MSB]) && (op_y[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        {op_cout, op_y} = sub_w;
        op_ovf = (bus.a[MSB] != bus.b[MSB]) && (op_y[MSB] != bus.a[MSB]);
      end
      OP_MUL: begin
      end
      default: op_ill = 1'b1;
    endcase
  end

  // A result is loaded either straight from an accepted single-cycle op or from the final MUL step.
  always_comb begin
    load   = 1'b0;
    y_d    = op_y;
    cout_d = op_cout;
    ovf_d  = op_ovf;
    ill_d  = op_ill;
    if (mul_last) begin
      load   = 1'b1;
      y_d    = acc_step[WIDTH-1:0];
      cout_d = |acc_step[2*WIDTH-1:WIDTH];
      ovf_d  = |acc_step[2*WIDTH-1:WIDTH];
      ill_d  = 1'b0;
    end else if (accept && !start_mul) begin
      load = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      y_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
      ill_q       <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      if (load) begin
        y_q    <= y_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        ill_q  <= ill_d;
        neg_q  <= y_d[MSB];
        zero_q <= (y_d == '0);
      end
      case (state_q)
        IDLE, DONE: begin
          if (start_mul) begin
            acc_q       <= '0;
            mcand_q     <= {{WIDTH{1'b0}}, bus.a};
            mplier_q    <= bus.b;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            state_q     <= BUSY;
          end else if (accept) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if ((state_q == DONE) && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        BUSY: begin
          acc_q    <= acc_step;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + SHW'(1);
          if (mul_last) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.negative  = neg_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = ill_q;

`ifdef SEQ_ALU_STICKY_OVF_EN
  logic sticky_q;

  // Setting takes priority so an overflow landing alongside ovf_clr is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (load && ovf_d) begin
      sticky_q <= 1'b1;
    end else if (ovf_clr) begin
      sticky_q <= 1'b0;
    end
  end

  assign sticky_ovf = sticky_q;
`endif
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed cases plus randomized ops against a
// behavioural model. Build with SEQ_ALU_STICKY_OVF_EN defined to also exercise sticky_ovf.
module tb_seq_alu;
  localparam int WIDTH = 8;
  localparam int SHW   = $clog2(WIDTH) + 1;
  localparam int MASK  = (1 << WIDTH) - 1;
  localparam int SMAX  = (1 << (WIDTH - 1)) - 1;
  localparam int SMIN  = -(1 << (WIDTH - 1));

  typedef struct {
    int y;
    bit cout;
    bit ovf;
    bit ill;
    bit isMul;
    int acceptCycle;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
`ifdef SEQ_ALU_STICKY_OVF_EN
  logic ovf_clr = 1'b0;
  logic sticky_ovf;
`endif

  seq_alu_if #(.WIDTH(WIDTH)) bus ();

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SEQ_ALU_STICKY_OVF_EN
    .ovf_clr   (ovf_clr),
    .sticky_ovf(sticky_ovf),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cycleCount  = 0;
  bit   randReady   = 1'b0;
  bit   sawAccept   = 1'b0;
  bit   sawPop      = 1'b0;
  int   snapOp      = 0;
  int   snapA       = 0;
  int   snapB       = 0;
  bit   snapCin     = 1'b0;
  exp_t expQ[$];

  // Reference behaviour from plain integer arithmetic on the op definitions.
  function automatic exp_t model(input int op, input int a, input int b, input bit cin);
    exp_t e;
    int sh, sa, sb, full;
    e.y = 0; e.cout = 1'b0; e.ovf = 1'b0; e.ill = 1'b0; e.isMul = 1'b0; e.acceptCycle = 0;
    sh = b % (1 << SHW);
    sa = (a > SMAX) ? a - (1 << WIDTH) : a;
    sb = (b > SMAX) ? b - (1 << WIDTH) : b;
    case (op)
      0: begin
        e.y    = (a << sh) & MASK;
        e.cout = (sh >= 1 && sh <= WIDTH) ? (((a >> (WIDTH - sh)) & 1) == 1) : 1'b0;
      end
      1: begin
        e.y    = a >> sh;
        e.cout = (sh >= 1 && sh <= WIDTH) ? (((a >> (sh - 1)) & 1) == 1) : 1'b0;
      end
      2: begin
        e.y = (sa >>> sh) & MASK;
        if (sh == 0)          e.cout = 1'b0;
        else if (sh > WIDTH)  e.cout = (sa < 0);
        else                  e.cout = (((sa >>> (sh - 1)) & 1) == 1);
      end
      3: e.y = (~a) & MASK;
      4: e.y = a & b;
      5: e.y = a | b;
      6: e.y = a ^ b;
      7: begin
        full   = a + b + int'(cin);
        e.y    = full & MASK;
        e.cout = full > MASK;
        e.ovf  = (sa + sb + int'(cin) > SMAX) || (sa + sb + int'(cin) < SMIN);
      end
      8: begin
        e.y    = (a - b) & MASK;
        e.cout = a >= b;
        e.ovf  = (sa - sb > SMAX) || (sa - sb < SMIN);
      end
      9: begin
        full    = a * b;
        e.y     = full & MASK;
        e.cout  = (full >> WIDTH) != 0;
        e.ovf   = (full >> WIDTH) != 0;
        e.isMul = 1'b1;
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Every falling edge out of reset: handshake signals and, when due, the result against the model.
  always @(negedge clk) begin
    bit shown;
    bit expReady;
    logic [WIDTH-1:0] ey;
    sawAccept = 1'b0;
    sawPop    = 1'b0;
    if (rst_n) begin
      shown = 1'b0;
      if (expQ.size() > 0)
        shown = (cycleCount - expQ[0].acceptCycle) >= (expQ[0].isMul ? WIDTH : 0);
      expReady = (expQ.size() == 0) || (shown && bus.out_ready);
      vectors++;
      if (bus.out_valid !== shown) begin
        miscompares++;
        $display("[TB] FAIL out_valid: got %b, expected %b at cycle %0d", bus.out_valid, shown, cycleCount);
      end
      vectors++;
      if (bus.in_ready !== expReady) begin
        miscompares++;
        $display("[TB] FAIL in_ready: got %b, expected %b at cycle %0d", bus.in_ready, expReady, cycleCount);
      end
      if (shown) begin
        ey = WIDTH'(expQ[0].y);
        vectors++;
        if ({bus.y, bus.cout, bus.overflow, bus.negative, bus.zero, bus.illegal} !==
            {ey, expQ[0].cout, expQ[0].ovf, ey[WIDTH-1], ey == '0, expQ[0].ill}) begin
          miscompares++;
          $display("[TB] FAIL result: got y=%h c=%b v=%b n=%b z=%b i=%b, expected y=%h c=%b v=%b n=%b z=%b i=%b at cycle %0d",
                   bus.y, bus.cout, bus.overflow, bus.negative, bus.zero, bus.illegal,
                   ey, expQ[0].cout, expQ[0].ovf, ey[WIDTH-1], ey == '0, expQ[0].ill, cycleCount);
        end
      end
      sawAccept = bus.in_valid && bus.in_ready;
      sawPop    = bus.out_valid && bus.out_ready;
      snapOp    = int'(bus.opcode);
      snapA     = int'(bus.a);
      snapB     = int'(bus.b);
      snapCin   = bus.cin;
    end
  end

  always @(posedge clk) begin
    exp_t e;
    cycleCount++;
    if (!rst_n) begin
      expQ.delete();
    end else begin
      if (sawPop && expQ.size() > 0) void'(expQ.pop_front());
      if (sawAccept) begin
        e = model(snapOp, snapA, snapB, snapCin);
        e.acceptCycle = cycleCount;
        expQ.push_back(e);
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic cin);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) done = 1'b1;
      @(posedge clk);
      #1;
      if (!done) begin
        n++;
        if (randReady) bus.out_ready = ($urandom_range(0, 1) == 1);
        if (n > 60) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL accept_timeout: in_ready low for %0d cycles, required acceptance", n);
          done = 1'b1;
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] expY, input logic expC,
                             input logic expV, input logic expI, input int expLat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.out_valid !== 1'b1 && n <= 60);
    vectors++;
    if (bus.out_valid !== 1'b1 || n != expLat) begin
      miscompares++;
      $display("[TB] FAIL %s latency: got %0d cycles (out_valid=%b), expected %0d", name, n, bus.out_valid, expLat);
    end
    vectors++;
    if ({bus.y, bus.cout, bus.overflow, bus.negative, bus.zero, bus.illegal} !==
        {expY, expC, expV, expY[WIDTH-1], expY == '0, expI}) begin
      miscompares++;
      $display("[TB] FAIL %s: got y=%h c=%b v=%b n=%b z=%b i=%b, expected y=%h c=%b v=%b n=%b z=%b i=%b",
               name, bus.y, bus.cout, bus.overflow, bus.negative, bus.zero, bus.illegal,
               expY, expC, expV, expY[WIDTH-1], expY == '0, expI);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.opcode    = 4'h0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.out_valid, bus.y, bus.cout, bus.overflow, bus.negative, bus.zero, bus.illegal} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got ov=%b y=%h c=%b v=%b n=%b z=%b i=%b, expected all zero",
               bus.out_valid, bus.y, bus.cout, bus.overflow, bus.negative, bus.zero, bus.illegal);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    nextCycle();
    applyStimulus(4'h0, 8'h81, 8'h01, 1'b0);
    checkOutput("lsl", 8'h02, 1'b1, 1'b0, 1'b0, 1);
    nextCycle();
    applyStimulus(4'h2, 8'h90, 8'h09, 1'b0);
    checkOutput("asr", 8'hFF, 1'b1, 1'b0, 1'b0, 1);
    nextCycle();
    applyStimulus(4'h7, 8'h7F, 8'h01, 1'b0);
    checkOutput("add_ovf", 8'h80, 1'b0, 1'b1, 1'b0, 1);
    nextCycle();
    applyStimulus(4'h8, 8'h00, 8'h01, 1'b1);
    checkOutput("sub_borrow", 8'hFF, 1'b0, 1'b0, 1'b0, 1);
    nextCycle();
    applyStimulus(4'h9, 8'h10, 8'h11, 1'b0);
    checkOutput("mul", 8'h10, 1'b1, 1'b1, 1'b0, WIDTH + 1);
    nextCycle();
    applyStimulus(4'hC, 8'h5A, 8'h33, 1'b1);
    checkOutput("reserved", 8'h00, 1'b0, 1'b0, 1'b1, 1);

    // Hold the result under backpressure, then release it while the next op is already waiting.
    nextCycle();
    bus.out_ready = 1'b0;
    applyStimulus(4'h4, 8'hFF, 8'h0F, 1'b0);
    checkOutput("and_bp", 8'h0F, 1'b0, 1'b0, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.y !== 8'h0F || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL hold_%0d: got y=%h ov=%b ir=%b, expected y=0f ov=1 ir=0", i, bus.y, bus.out_valid, bus.in_ready);
      end
    end
    nextCycle();
    bus.out_ready = 1'b1;
    applyStimulus(4'h6, 8'hCC, 8'hAA, 1'b0);
    checkOutput("xor_b2b", 8'h66, 1'b0, 1'b0, 1'b0, 1);

`ifdef SEQ_ALU_STICKY_OVF_EN
    nextCycle();
    ovf_clr = 1'b1;
    nextCycle();
    ovf_clr = 1'b0;
    @(negedge clk);
    vectors++;
    if (sticky_ovf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sticky_clr0: got %b, expected 0", sticky_ovf);
    end
    nextCycle();
    applyStimulus(4'h7, 8'h7F, 8'h01, 1'b0);
    checkOutput("sticky_add", 8'h80, 1'b0, 1'b1, 1'b0, 1);
    nextCycle();
    applyStimulus(4'h4, 8'h01, 8'h01, 1'b0);
    checkOutput("sticky_and", 8'h01, 1'b0, 1'b0, 1'b0, 1);
    vectors++;
    if (sticky_ovf !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sticky_set: got %b, expected 1", sticky_ovf);
    end
    nextCycle();
    ovf_clr = 1'b1;
    nextCycle();
    ovf_clr = 1'b0;
    @(negedge clk);
    vectors++;
    if (sticky_ovf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sticky_clr1: got %b, expected 0", sticky_ovf);
    end
`endif

    // Random ops with random backpressure; the compare process checks every cycle.
    randReady = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        nextCycle();
        bus.out_ready = ($urandom_range(0, 1) == 1);
      end
      applyStimulus(4'($urandom_range(0, 15)), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    end
    randReady     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (WIDTH + 4) nextCycle();

    // Abandon a MUL midway with reset; its result must never show up.
    applyStimulus(4'h9, 8'hB7, 8'h5D, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.y !== '0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got ov=%b y=%h, expected ov=0 y=00", bus.out_valid, bus.y);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ready_after_reset: got %b, expected 1", bus.in_ready);
    end
    repeat (WIDTH + 4) @(negedge clk);
    nextCycle();
    applyStimulus(4'h5, 8'hA0, 8'h05, 1'b0);
    checkOutput("or_after_reset", 8'hA5, 1'b0, 1'b0, 1'b0, 1);
    repeat (3) nextCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
